spm_wb_sequencer: RTL and testbench

//  Wishbone slave front-end that sits directly upstream of the serial-parallel multiplier (SPM) core
//  in the user project. Holds operands X and Y in registers and clears the core. Streams Y LSB-first

---
 rtl/spm_wb_sequencer.sv | 92 +++++++++
 tb/tb_spm_wb_sequencer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/spm_wb_sequencer.sv
// spm_wb_sequencer: Wishbone front-end that loads operands, sequences the serial-parallel multiplier and collects the product
// Ports: wb_clk_i/wb_rst_n_i clock and async active-low reset; wbs_* Wishbone slave;
//        spm_x_o/spm_y_bit_o/spm_clr_o/spm_p_bit_i multiplier core interface; irq_o done interrupt (level)
module spm_wb_sequencer #(
  parameter int          BITS      = 32,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          SPM_LAT   = 1
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_n_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_adr_i,
  input  logic [31:0]     wbs_dat_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_dat_o,
  output logic [BITS-1:0] spm_x_o,
  output logic            spm_y_bit_o,
  output logic            spm_clr_o,
  input  logic            spm_p_bit_i,
  output logic            irq_o
);
  localparam int CW = $clog2(2*BITS+SPM_LAT+1);
  localparam logic [CW-1:0] LAST_C = CW'(2*BITS+SPM_LAT-1);
  localparam logic [CW-1:0] LAT_C  = CW'(SPM_LAT);
  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN} state_t;
  state_t            r_state, w_next;
  logic [BITS-1:0]   r_x, r_y, r_ysh;
  logic [2*BITS-1:0] r_p;
  logic [CW-1:0]     r_cnt;
  logic              r_done, r_irq_en, r_ack;
  logic [31:0]       r_dat, w_rdata, w_mask, w_xw, w_yw;
  logic [63:0]       w_p64;
  logic [2:0]        w_idx;
  logic              w_req, w_wr, w_busy, w_start, w_last, w_unused;
  assign w_idx    = wbs_adr_i[4:2];
  // a request is blocked while ack is high so a held strobe is acked every other cycle
  assign w_req    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:5] == BASE_ADDR[31:5]) & ~r_ack;
  assign w_wr     = w_req & wbs_we_i;
  assign w_busy   = r_state != S_IDLE;
  assign w_start  = w_wr & (w_idx == 3'd2) & wbs_sel_i[0] & wbs_dat_i[0] & ~w_busy;
  assign w_last   = (r_state == S_RUN) & (r_cnt == LAST_C);
  assign w_mask   = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign w_xw     = (32'(r_x) & ~w_mask) | (wbs_dat_i & w_mask);
  assign w_yw     = (32'(r_y) & ~w_mask) | (wbs_dat_i & w_mask);
  assign w_p64    = 64'(r_p);
  assign w_unused = ^wbs_adr_i[1:0];
  always_comb begin
    w_rdata = w_idx == 3'd0 ? 32'(r_x) :
              w_idx == 3'd1 ? 32'(r_y) :
              w_idx == 3'd2 ? {29'b0, r_irq_en, r_done, w_busy} :
              w_idx == 3'd3 ? w_p64[31:0] :
              w_idx == 3'd4 ? w_p64[63:32] : 32'b0;
    w_next  = (r_state == S_IDLE && w_start) ? S_CLEAR :
              r_state == S_CLEAR             ? S_RUN :
              w_last                         ? S_IDLE : r_state;
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state  <= S_IDLE;
      r_x      <= '0;
      r_y      <= '0;
      r_ysh    <= '0;
      r_p      <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_irq_en <= 1'b0;
      r_ack    <= 1'b0;
      r_dat    <= '0;
    end else begin
      r_ack   <= w_req;
      r_dat   <= (w_req & ~wbs_we_i) ? w_rdata : 32'b0;
      r_state <= w_next;
      if (w_wr && !w_busy && w_idx == 3'd0) r_x <= BITS'(w_xw);
      if (w_wr && !w_busy && w_idx == 3'd1) r_y <= BITS'(w_yw);
      if (w_wr && w_idx == 3'd2 && wbs_sel_i[0]) r_irq_en <= wbs_dat_i[1];
      r_cnt   <= (r_state == S_RUN) ? r_cnt + 1'b1 : '0;
      // zeros shift in behind Y so the core sees 0 once all operand bits are out
      r_ysh   <= w_start ? r_y : (r_state == S_RUN) ? r_ysh >> 1 : r_ysh;
      if (r_state == S_RUN && r_cnt >= LAT_C) r_p <= {spm_p_bit_i, r_p[2*BITS-1:1]};
      r_done  <= w_start ? 1'b0 : w_last ? 1'b1 : r_done;
    end
  end
  assign wbs_ack_o   = r_ack;
  assign wbs_dat_o   = r_dat;
  assign spm_x_o     = r_x;
  assign spm_y_bit_o = (r_state == S_RUN) & r_ysh[0];
  assign spm_clr_o   = r_state == S_CLEAR;
  assign irq_o       = r_done & r_irq_en;
endmodule

// File: tb/tb_spm_wb_sequencer.sv
// tb_spm_wb_sequencer: directed checks of the SPM Wishbone sequencer against a behavioural serial multiplier core
module tb_spm_wb_sequencer;
  localparam logic [31:0] B = 32'h3000_0000;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, wdat = '0;
  logic        ack, ybit, clr, pbit, irq;
  logic [31:0] dat, x;
  int          total = 0, bad = 0, cyc_n = 0, t0;
  logic [31:0] q;
  logic        ok;
  spm_wb_sequencer dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(dat),
    .spm_x_o(x), .spm_y_bit_o(ybit), .spm_clr_o(clr), .spm_p_bit_i(pbit), .irq_o(irq)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;
  // core model: carry-save serial multiplier, product bit k emerges one cycle after y bit k
  logic [31:0] c;
  logic [32:0] t;
  assign t = {1'b0, c} + (ybit ? {1'b0, x} : 33'd0);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c    <= '0;
      pbit <= 1'b0;
    end else if (clr) begin
      c    <= '0;
      pbit <= 1'b0;
    end else begin
      c    <= t[32:1];
      pbit <= t[0];
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic wb(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    output logic [31:0] rq, output logic rok);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    rok = 1'b0; rq = '0;
    for (int i = 0; i < 4 && !rok; i++) begin
      @(posedge clk);
      #1;
      if (ack) begin
        rok = 1'b1;
        rq  = dat;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask
  task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rq;
    logic rok;
    wb(1'b1, a, d, s, rq, rok);
    chk({tag, "_ack"}, {31'b0, rok}, 32'd1);
  endtask
  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rq;
    logic rok;
    wb(1'b0, a, 32'h0, 4'hF, rq, rok);
    chk({tag, "_ack"}, {31'b0, rok}, 32'd1);
    chk(tag, rq, exp);
  endtask
  task automatic wait_irq(input string tag, input int start, input int exp_n);
    while (!irq && cyc_n - start < 300) begin
      @(posedge clk);
      #1;
    end
    chk(tag, 32'(cyc_n - start), 32'(exp_n));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog observed=hang expected=finish");
    $fatal(1);
  end
  initial begin
    #12;
    chk("rst_ack", {31'b0, ack}, 32'd0);
    chk("rst_dat", dat, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    chk("rst_spm", {29'b0, ybit, clr, |x}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd("rst_ctrl", B + 32'h08, 32'h0);
    wr("be_x", B, 32'hAABB_CCDD, 4'b0010);
    rd("be_x_rd", B, 32'h0000_CC00);
    chk("be_spm_x", x, 32'h0000_CC00);
    wb(1'b0, B + 32'h100, 32'h0, 4'hF, q, ok);
    chk("miss_noack", {31'b0, ok}, 32'd0);
    wr("hole_wr", B + 32'h14, 32'h1234_5678, 4'hF);
    rd("hole_rd", B + 32'h14, 32'h0);
    wr("m_x", B, 32'd3, 4'hF);
    wr("m_y", B + 32'h04, 32'd5, 4'hF);
    wr("m_go", B + 32'h08, 32'd3, 4'h1);
    t0 = cyc_n;
    rd("m_busy", B + 32'h08, 32'h5);
    wait_irq("m_lat", t0, 66);
    rd("m_done", B + 32'h08, 32'h6);
    rd("m_sticky", B + 32'h08, 32'h6);
    rd("m_plo", B + 32'h0C, 32'd15);
    rd("m_phi", B + 32'h10, 32'd0);
    rd("m_y_rd", B + 32'h04, 32'd5);
    wr("x_x", B, 32'hFFFF_FFFF, 4'hF);
    wr("x_y", B + 32'h04, 32'hFFFF_FFFF, 4'hF);
    wr("x_go", B + 32'h08, 32'd3, 4'h1);
    t0 = cyc_n;
    wait_irq("x_lat", t0, 66);
    chk("x_irq", {31'b0, irq}, 32'd1);
    rd("x_phi", B + 32'h10, 32'hFFFF_FFFE);
    rd("x_plo", B + 32'h0C, 32'h0000_0001);
    wr("x_irqoff", B + 32'h08, 32'd0, 4'h1);
    chk("x_irq_off", {31'b0, irq}, 32'd0);
    rd("x_ctrl", B + 32'h08, 32'h2);
    wr("l_x", B, 32'd2, 4'hF);
    wr("l_y", B + 32'h04, 32'd4, 4'hF);
    wr("l_go", B + 32'h08, 32'd3, 4'h1);
    t0 = cyc_n;
    while (cyc_n - t0 < 9) begin
      @(posedge clk);
      #1;
    end
    wr("l_y9", B + 32'h04, 32'd9, 4'hF);
    wr("l_go2", B + 32'h08, 32'd3, 4'h1);
    wait_irq("l_lat", t0, 66);
    rd("l_plo", B + 32'h0C, 32'd8);
    rd("l_y_rd", B + 32'h04, 32'd4);
    wr("r_go", B + 32'h08, 32'd3, 4'h1);
    t0 = cyc_n;
    while (cyc_n - t0 < 21) begin
      @(posedge clk);
      #1;
    end
    #1;
    rst_n = 1'b0;
    #1;
    chk("r_irq", {31'b0, irq}, 32'd0);
    chk("r_spm", {29'b0, ybit, clr, |x}, 32'd0);
    chk("r_ack", {31'b0, ack}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd("r_ctrl", B + 32'h08, 32'h0);
    rd("r_plo", B + 32'h0C, 32'h0);
    rd("r_phi", B + 32'h10, 32'h0);
    wr("f_x", B, 32'd7, 4'hF);
    wr("f_y", B + 32'h04, 32'd6, 4'hF);
    wr("f_go", B + 32'h08, 32'd3, 4'h1);
    t0 = cyc_n;
    wait_irq("f_lat", t0, 66);
    rd("f_plo", B + 32'h0C, 32'd42);
    rd("f_phi", B + 32'h10, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
